// File: rtl/score_keeper_if.sv
// Score keeper port bundle: game inputs from the ball mover, score/high-score/segment outputs.
// Latency: none (wires only).
// Backpressure: none; all signals are levels sampled or presented every cycle.
interface score_keeper_if;
  logic        start;
  logic        hit_bar;
  logic        endgame;
  logic [11:0] score_bcd;
  logic [11:0] high_bcd;
  logic [1:0]  game_state;
  logic        new_record;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic [6:0]  hex4;
  logic [6:0]  hex5;

  // Game controller side: drives the levels, watches the score.
  modport master (
    output start, hit_bar, endgame,
    input  score_bcd, high_bcd, game_state, new_record,
    input  hex0, hex1, hex2, hex3, hex4, hex5
  );

  // Score keeper side.
  modport slave (
    input  start, hit_bar, endgame,
    output score_bcd, high_bcd, game_state, new_record,
    output hex0, hex1, hex2, hex3, hex4, hex5
  );
endinterface

// File: rtl/score_keeper.sv
// Game score keeper: counts bar hits in BCD, tracks high score, drives six 7-segment digits.
// Latency: score/state one cycle after the input edge; hex digits one further cycle.
// Backpressure: none; inputs are levels sampled every cycle, outputs always valid.
module score_keeper #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  score_keeper_if.slave sk
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    OVER    = 2'd2
  } state_t;

  state_t      state;
  logic        hit_prev;
  logic        hit_evt;
  logic        over_first;
  logic [11:0] score;
  logic [11:0] high;
  logic        new_rec;

  // Three-digit BCD increment that sticks at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // BCD digit to gfedcba segments, polarity selected by SEG_ACTIVE_LOW.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  // Rising edge of the hit-zone level; sampling continues in every state.
  assign hit_evt = sk.hit_bar & ~hit_prev;

  // Delayed copy of hit_bar for edge detection.
  always_ff @(posedge clock) begin
    if (reset) hit_prev <= 1'b0;
    else       hit_prev <= sk.hit_bar;
  end

  // Game FSM with score, high score and record flag as registered outputs.
  // The high-score compare is done one cycle after entering OVER so a hit
  // landing on the same edge as endgame is already in the score.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      score      <= 12'h000;
      high       <= 12'h000;
      new_rec    <= 1'b0;
      over_first <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          score      <= 12'h000;
          new_rec    <= 1'b0;
          over_first <= 1'b0;
          if (sk.start && !sk.endgame) state <= PLAYING;
        end
        PLAYING: begin
          over_first <= 1'b0;
          if (hit_evt) score <= bcd_inc(score);
          if (sk.endgame) begin
            state      <= OVER;
            over_first <= 1'b1;
          end else if (!sk.start) begin
            // Abort: no high-score update, score dropped immediately.
            state   <= IDLE;
            score   <= 12'h000;
            new_rec <= 1'b0;
          end
        end
        OVER: begin
          over_first <= 1'b0;
          // Packed BCD with digits <= 9 orders the same as plain unsigned.
          if (over_first && (score > high)) begin
            high    <= score;
            new_rec <= 1'b1;
          end
          if (!sk.start) begin
            state   <= IDLE;
            score   <= 12'h000;
            new_rec <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          over_first <= 1'b0;
        end
      endcase
    end
  end

  // Segment decode registered one cycle behind the BCD registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sk.hex0 <= seg_decode(4'd0);
      sk.hex1 <= seg_decode(4'd0);
      sk.hex2 <= seg_decode(4'd0);
      sk.hex3 <= seg_decode(4'd0);
      sk.hex4 <= seg_decode(4'd0);
      sk.hex5 <= seg_decode(4'd0);
    end else begin
      sk.hex0 <= seg_decode(score[3:0]);
      sk.hex1 <= seg_decode(score[7:4]);
      sk.hex2 <= seg_decode(score[11:8]);
      sk.hex3 <= seg_decode(high[3:0]);
      sk.hex4 <= seg_decode(high[7:4]);
      sk.hex5 <= seg_decode(high[11:8]);
    end
  end

  assign sk.score_bcd  = score;
  assign sk.high_bcd   = high;
  assign sk.game_state = state;
  assign sk.new_record = new_rec;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: stimulus pushes expected snapshots, a monitor compares them.
// Latency: snapshots are taken after inputs have settled for several cycles.
// Backpressure: none.
module tb_score_keeper;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  score_keeper_if sk();

  score_keeper #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .sk    (sk)
  );

  typedef struct packed {
    logic [11:0] score;
    logic [11:0] high;
    logic [1:0]  st;
    logic        nr;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  // Active-low gfedcba reference patterns.
  function automatic logic [6:0] seg_al(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string what, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", what, act, req);
    end
  endtask

  // Monitor: one queued snapshot is compared per falling edge.
  exp_t  m_e;
  string m_n;
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        m_e = exp_q.pop_front();
        m_n = name_q.pop_front();
        check({m_n, ".score"},      sk.score_bcd,                m_e.score);
        check({m_n, ".high"},       sk.high_bcd,                 m_e.high);
        check({m_n, ".state"},      {10'd0, sk.game_state},      {10'd0, m_e.st});
        check({m_n, ".new_record"}, {11'd0, sk.new_record},      {11'd0, m_e.nr});
        check({m_n, ".hex0"},       {5'd0, sk.hex0},             {5'd0, seg_al(m_e.score[3:0])});
        check({m_n, ".hex1"},       {5'd0, sk.hex1},             {5'd0, seg_al(m_e.score[7:4])});
        check({m_n, ".hex2"},       {5'd0, sk.hex2},             {5'd0, seg_al(m_e.score[11:8])});
        check({m_n, ".hex3"},       {5'd0, sk.hex3},             {5'd0, seg_al(m_e.high[3:0])});
        check({m_n, ".hex4"},       {5'd0, sk.hex4},             {5'd0, seg_al(m_e.high[7:4])});
        check({m_n, ".hex5"},       {5'd0, sk.hex5},             {5'd0, seg_al(m_e.high[11:8])});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    sk.hit_bar = 1'b1;
    tick(hi);
    sk.hit_bar = 1'b0;
    tick(lo);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) pulse(1, 1);
  endtask

  task automatic expect_snap(input string name, input logic [11:0] sc, input logic [11:0] hi,
                             input logic [1:0] st, input logic nr);
    exp_t e;
    e.score = sc;
    e.high  = hi;
    e.st    = st;
    e.nr    = nr;
    exp_q.push_back(e);
    name_q.push_back(name);
    tick(1);
  endtask

  // Plays one game from IDLE: n hits, then endgame; leaves the DUT in OVER.
  task automatic play_to_over(input int n);
    sk.start = 1'b1;
    tick(2);
    hits(n);
    tick(2);
    sk.endgame = 1'b1;
    tick(3);
  endtask

  task automatic back_to_idle();
    sk.start   = 1'b0;
    sk.endgame = 1'b0;
    tick(3);
  endtask

  initial begin
    reset      = 1'b1;
    sk.start   = 1'b0;
    sk.hit_bar = 1'b0;
    sk.endgame = 1'b0;
    tick(3);
    expect_snap("in_reset", 12'h000, 12'h000, 2'd0, 1'b0);
    reset = 1'b0;
    tick(2);
    expect_snap("after_reset", 12'h000, 12'h000, 2'd0, 1'b0);

    // Three 5-high/10-low pulses.
    sk.start = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) pulse(5, 10);
    tick(3);
    expect_snap("three_hits", 12'h003, 12'h000, 2'd1, 1'b0);

    // Long hold counts once.
    pulse(200, 3);
    expect_snap("hold_200", 12'h004, 12'h000, 2'd1, 1'b0);

    // First game ends at 005 with high 000.
    hits(1);
    tick(2);
    sk.endgame = 1'b1;
    tick(3);
    expect_snap("game1_over", 12'h005, 12'h005, 2'd2, 1'b1);
    back_to_idle();
    expect_snap("game1_idle", 12'h000, 12'h005, 2'd0, 1'b0);

    // Lower score does not update.
    play_to_over(3);
    expect_snap("game2_lower", 12'h003, 12'h005, 2'd2, 1'b0);
    back_to_idle();
    expect_snap("game2_idle", 12'h000, 12'h005, 2'd0, 1'b0);

    // Reset mid-game clears everything including high score, with a hit pending.
    sk.start = 1'b1;
    tick(2);
    hits(2);
    tick(2);
    expect_snap("pre_reset", 12'h002, 12'h005, 2'd1, 1'b0);
    reset      = 1'b1;
    sk.hit_bar = 1'b1;
    tick(2);
    expect_snap("mid_reset", 12'h000, 12'h000, 2'd0, 1'b0);
    sk.hit_bar = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(2);

    // High 002, then abort a game at 007.
    hits(2);
    tick(2);
    sk.endgame = 1'b1;
    tick(3);
    expect_snap("high_2", 12'h002, 12'h002, 2'd2, 1'b1);
    back_to_idle();
    sk.start = 1'b1;
    tick(2);
    hits(7);
    tick(2);
    expect_snap("score_7", 12'h007, 12'h002, 2'd1, 1'b0);
    sk.start = 1'b0;
    tick(3);
    expect_snap("abort", 12'h000, 12'h002, 2'd0, 1'b0);

    // High 004, then hit and endgame on the same edge.
    play_to_over(4);
    expect_snap("high_4", 12'h004, 12'h004, 2'd2, 1'b1);
    back_to_idle();
    sk.start = 1'b1;
    tick(2);
    hits(4);
    tick(3);
    expect_snap("pre_same", 12'h004, 12'h004, 2'd1, 1'b0);
    sk.hit_bar = 1'b1;
    sk.endgame = 1'b1;
    tick(3);
    expect_snap("same_cycle", 12'h005, 12'h005, 2'd2, 1'b1);
    sk.hit_bar = 1'b0;
    tick(2);
    hits(2);
    tick(3);
    expect_snap("over_hold", 12'h005, 12'h005, 2'd2, 1'b1);
    back_to_idle();
    expect_snap("same_idle", 12'h000, 12'h005, 2'd0, 1'b0);

    // Equal score is not a record.
    play_to_over(5);
    expect_snap("equal", 12'h005, 12'h005, 2'd2, 1'b0);
    back_to_idle();

    // BCD carries and saturation.
    sk.start = 1'b1;
    tick(2);
    hits(9);
    tick(3);
    expect_snap("s009", 12'h009, 12'h005, 2'd1, 1'b0);
    hits(1);
    tick(3);
    expect_snap("s010", 12'h010, 12'h005, 2'd1, 1'b0);
    hits(89);
    tick(3);
    expect_snap("s099", 12'h099, 12'h005, 2'd1, 1'b0);
    hits(1);
    tick(3);
    expect_snap("s100", 12'h100, 12'h005, 2'd1, 1'b0);
    hits(899);
    tick(3);
    expect_snap("s999", 12'h999, 12'h005, 2'd1, 1'b0);
    hits(1);
    tick(3);
    expect_snap("sat999", 12'h999, 12'h005, 2'd1, 1'b0);

    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter: SEG_ACTIVE_LOW, default 1, meaning 1 = segment lit when driven 0, 0 = segment lit when driven 1.
REQ-002 Port: clock  in  1  system clock; sole clock, all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  game-enable level switch, same signal fed to the ball mover.
REQ-005 Port: hit_bar  in  1  level from ball mover, high while the ball is inside the bar hit zone.
REQ-006 Port: endgame  in  1  level from ball mover, high once the ball has reached the bottom edge.
REQ-007 Port: score_bcd  out  12  current score, 3 BCD digits, [11:8] hundreds, [3:0] units.
REQ-008 Port: high_bcd  out  12  highest score since reset, same encoding.
REQ-009 Port: game_state  out  2  0 = IDLE, 1 = PLAYING, 2 = OVER; 3 unused.
REQ-010 Port: new_record  out  1  high when the finished game raised high_bcd.
REQ-011 Port: hex0..hex5  out  7 each  segments gfedcba; hex2..hex0 = score hundreds..units, hex5..hex3 = high hundreds..units.

Function
REQ-012 FSM IDLE: score cleared to 000, new_record cleared; go PLAYING when start=1 and endgame=0; otherwise stay.
REQ-013 FSM PLAYING: count hits; go OVER when endgame=1; go IDLE when start=0 (abort, no high-score update).
REQ-014 FSM OVER: score frozen; high-score compare per REQ-018; go IDLE when start=0; start=1 holds OVER.
REQ-015 Hit detection: registered copy hit_prev of hit_bar; hit event = hit_bar=1 and hit_prev=0; hit_prev updates every cycle in all states.
REQ-016 On a hit event while in PLAYING, score increments by 1 at that clock edge, visible on score_bcd the next cycle; events in IDLE/OVER ignored.
REQ-017 BCD arithmetic: units 9 -> 0 with carry to tens, tens 9 -> 0 with carry to hundreds; at 999 score saturates and stays 999.
REQ-018 On the first cycle in OVER: if score > high_bcd (numeric compare), high_bcd <= score and new_record <= 1; equal score does not update.
REQ-019 Hit event and endgame=1 in the same PLAYING cycle: hit counted, transition to OVER; the compare uses the incremented score.
REQ-020 new_record holds through OVER; cleared on entry to IDLE.
REQ-021 hexN are registered decodes of the corresponding digit (one cycle after the BCD value); digits 0-9 standard patterns; with SEG_ACTIVE_LOW=1, 0 -> 1000000, 1 -> 1111001, 8 -> 0000000; no leading-zero blanking.
REQ-022 Outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-023 reset=1 forces, on the next edge: state IDLE, score_bcd 000, high_bcd 000, new_record 0, hit_prev 0, all hex showing "0".
REQ-024 Reset mid-game (any state) takes effect identically; high score is cleared only by reset, never by start.
REQ-025 Reset has priority over every other input in the same cycle.

Verification
REQ-026 Reset, start=1, three hit_bar pulses each 5 cycles high with 10-cycle gaps -> score_bcd=003, hex0=0110000 (active-low "3").
REQ-027 PLAYING, hit_bar held high 200 cycles -> score increments exactly once.
REQ-028 Preload score 009 via hits, one more hit -> 010; drive to 999, one more hit -> stays 999.
REQ-029 Game ends with score 005 (high 000) -> OVER, high_bcd=005, new_record=1; start=0 -> IDLE, score 000, new_record 0; next game ends at 003 -> high_bcd stays 005, new_record 0.
REQ-030 Same-cycle hit event and endgame=1 with score 004, high 004 -> score 005, high_bcd=005, new_record=1.
REQ-031 start=0 during PLAYING with score 007, high 002 -> IDLE, score 000, high_bcd stays 002.
